// File: rtl/idli_pkg.sv
// Shared types and defaults for the idli core and its retire-trace unit.
package idli_pkg;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_REG  = 2'd1,
        DST_P    = 2'd2
    } dst_t;

    localparam int TRC_NUM_REGS = 16;
    localparam int TRC_REG_W    = $clog2(TRC_NUM_REGS);
    localparam int TRC_SEQ_W    = 16;
    localparam int TRC_DROP_W   = 8;
    localparam int TRC_DEPTH    = 8;
    localparam int TRC_CTR_W    = 2;

    typedef struct packed {
        logic [TRC_SEQ_W-1:0] seq;
        dst_t                 dst;
        logic [TRC_REG_W-1:0] dst_reg;
    } trc_rec_t;

endpackage

// File: rtl/idli_trace_fifo_m.sv
// Generic synchronous FIFO; a pop in the same cycle lets a push into a full FIFO.
module idli_trace_fifo_m #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the output is masked while empty so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/idli_trace_m.sv
// Retire-trace unit: latches each 4-GCK slot, records retirements into a FIFO,
// and keeps clearable register/predicate write scoreboards plus drop accounting.
module idli_trace_m
    import idli_pkg::*;
#(
    parameter int NUM_REGS = TRC_NUM_REGS,
    parameter int DEPTH    = TRC_DEPTH,
    parameter int SEQ_W    = TRC_SEQ_W,
    parameter int DROP_W   = TRC_DROP_W,
    parameter int CTR_W    = TRC_CTR_W
) (
    input  logic                        i_trc_gck,
    input  logic                        i_trc_rst,
    input  logic                        i_trc_en,
    input  logic [CTR_W-1:0]            i_trc_ctr,
    input  logic                        i_trc_run,
    input  dst_t                        i_trc_dst,
    input  logic [$clog2(NUM_REGS)-1:0] i_trc_dst_reg,
    output logic                        o_trc_valid,
    input  logic                        i_trc_ready,
    output trc_rec_t                    o_trc_rec,
    output logic [NUM_REGS-1:0]         o_trc_reg_sb,
    input  logic [NUM_REGS-1:0]         i_trc_sb_clr,
    output logic                        o_trc_pred_sb,
    input  logic                        i_trc_pred_clr,
    output logic                        o_trc_ovf,
    input  logic                        i_trc_ovf_clr,
    output logic [DROP_W-1:0]           o_trc_drop_cnt
);

    localparam int REG_W = $clog2(NUM_REGS);

    logic                slot_start;
    logic                slot_end;
    logic                capture;
    logic                run_q;
    dst_t                dst_q;
    logic [REG_W-1:0]    reg_q;
    logic [SEQ_W-1:0]    seq_q;
    logic [NUM_REGS-1:0] reg_set;
    logic                pred_set;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                drop;
    trc_rec_t            rec_in;
    logic [$bits(trc_rec_t)-1:0] head_data;

    assign slot_start = (i_trc_ctr == '0);
    assign slot_end   = (i_trc_ctr == '1);
    assign capture    = i_trc_run & i_trc_en;

    always_ff @(posedge i_trc_gck) begin
        if (i_trc_rst) begin
            run_q <= 1'b0;
            dst_q <= DST_NONE;
            reg_q <= '0;
        end else if (slot_start) begin
            run_q <= capture;
            dst_q <= i_trc_dst;
            reg_q <= i_trc_dst_reg;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        reg_set  = '0;
        pred_set = 1'b0;
        if (slot_start && capture) begin
            if (i_trc_dst == DST_REG) reg_set[i_trc_dst_reg] = 1'b1;
            if (i_trc_dst == DST_P)   pred_set = 1'b1;
        end
    end

    // Clear first, then OR in the set so a coincident set wins.
    always_ff @(posedge i_trc_gck) begin
        if (i_trc_rst) begin
            o_trc_reg_sb  <= '0;
            o_trc_pred_sb <= 1'b0;
        end else begin
            o_trc_reg_sb  <= (o_trc_reg_sb & ~i_trc_sb_clr) | reg_set;
            o_trc_pred_sb <= (o_trc_pred_sb & ~i_trc_pred_clr) | pred_set;
        end
    end

    assign push = slot_end & run_q;
    assign pop  = o_trc_valid & i_trc_ready;
    assign drop = push & fifo_full & ~pop;

    always_comb begin
        rec_in         = '0;
        rec_in.seq     = TRC_SEQ_W'(seq_q);
        rec_in.dst     = dst_q;
        rec_in.dst_reg = TRC_REG_W'(reg_q);
    end

    // The sequence advances on every retirement, dropped or not, so gaps are visible downstream.
    always_ff @(posedge i_trc_gck) begin
        if (i_trc_rst)  seq_q <= '0;
        else if (push)  seq_q <= seq_q + 1'b1;
    end

    always_ff @(posedge i_trc_gck) begin
        if (i_trc_rst) begin
            o_trc_ovf      <= 1'b0;
            o_trc_drop_cnt <= '0;
        end else begin
            if (drop)               o_trc_ovf <= 1'b1;
            else if (i_trc_ovf_clr) o_trc_ovf <= 1'b0;

            if (i_trc_ovf_clr)                     o_trc_drop_cnt <= drop ? DROP_W'(1) : '0;
            else if (drop && o_trc_drop_cnt != '1) o_trc_drop_cnt <= o_trc_drop_cnt + 1'b1;
        end
    end

    idli_trace_fifo_m #(
        .WIDTH ($bits(trc_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_trc_gck),
        .rst       (i_trc_rst),
        .push      (push),
        .push_data (rec_in),
        .full      (fifo_full),
        .pop       (i_trc_ready),
        .valid     (o_trc_valid),
        .pop_data  (head_data)
    );

    assign o_trc_rec = trc_rec_t'(head_data);

endmodule

// File: tb/tb_idli_trace_m.sv
// Directed self-checking bench for idli_trace_m: scoreboards, retire records, overflow and reset.
module tb_idli_trace_m;
    import idli_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  ctr = '0;
    logic        run = 1'b0;
    dst_t        dst = DST_NONE;
    logic [3:0]  dst_reg = '0;
    logic        valid;
    logic        ready = 1'b0;
    trc_rec_t    rec;
    logic [15:0] reg_sb;
    logic [15:0] sb_clr = '0;
    logic        pred_sb;
    logic        pred_clr = 1'b0;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    idli_trace_m dut (
        .i_trc_gck      (clk),
        .i_trc_rst      (rst),
        .i_trc_en       (en),
        .i_trc_ctr      (ctr),
        .i_trc_run      (run),
        .i_trc_dst      (dst),
        .i_trc_dst_reg  (dst_reg),
        .o_trc_valid    (valid),
        .i_trc_ready    (ready),
        .o_trc_rec      (rec),
        .o_trc_reg_sb   (reg_sb),
        .i_trc_sb_clr   (sb_clr),
        .o_trc_pred_sb  (pred_sb),
        .i_trc_pred_clr (pred_clr),
        .o_trc_ovf      (ovf),
        .i_trc_ovf_clr  (ovf_clr),
        .o_trc_drop_cnt (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int s, input dst_t d, input int r);
        trc_rec_t t;
        t.seq     = 16'(s);
        t.dst     = d;
        t.dst_reg = 4'(r);
        return 32'(t);
    endfunction

    // One GCK cycle: drive slot inputs, then sample 1 time unit after the edge.
    task automatic tick(input int c, input logic r, input logic e, input dst_t d, input int rg);
        ctr     = 2'(c);
        run     = r;
        en      = e;
        dst     = d;
        dst_reg = 4'(rg);
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic r, input logic e, input dst_t d, input int rg);
        for (int c = 0; c < 4; c++) tick(c, r, e, d, rg);
    endtask

    task automatic idle_rest();
        for (int c = 1; c < 4; c++) tick(c, 1'b0, 1'b1, DST_NONE, 0);
    endtask

    initial begin
        // Reset state
        tick(0, 1'b0, 1'b0, DST_NONE, 0);
        tick(0, 1'b0, 1'b0, DST_NONE, 0);
        rst = 1'b0;
        check("rst_valid", 32'(valid), 0);
        check("rst_rec", 32'(rec), 0);
        check("rst_reg_sb", 32'(reg_sb), 0);
        check("rst_pred_sb", 32'(pred_sb), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_drop", 32'(drop_cnt), 0);

        // Single DST_REG r5 retire, visible for one cycle with ready=1
        ready = 1'b1;
        slot(1'b1, 1'b1, DST_REG, 5);
        check("r5_valid", 32'(valid), 1);
        check("r5_rec", 32'(rec), mk(0, DST_REG, 5));
        check("r5_reg_sb", 32'(reg_sb), 32'h0020);
        tick(0, 1'b0, 1'b1, DST_NONE, 0);
        check("r5_popped", 32'(valid), 0);
        idle_rest();

        // Predicate set, set-wins-over-clear, then clear alone
        slot(1'b1, 1'b1, DST_P, 0);
        check("p_sb_set", 32'(pred_sb), 1);
        check("p_rec", 32'(rec), mk(1, DST_P, 0));
        pred_clr = 1'b1;
        tick(0, 1'b1, 1'b1, DST_P, 0);
        pred_clr = 1'b0;
        check("p_set_wins", 32'(pred_sb), 1);
        for (int c = 1; c < 4; c++) tick(c, 1'b1, 1'b1, DST_P, 0);
        check("p_rec2", 32'(rec), mk(2, DST_P, 0));
        pred_clr = 1'b1;
        sb_clr   = 16'hffff;
        tick(0, 1'b0, 1'b1, DST_NONE, 0);
        pred_clr = 1'b0;
        sb_clr   = '0;
        check("p_clr_alone", 32'(pred_sb), 0);
        check("reg_clr_alone", 32'(reg_sb), 0);
        check("p_popped", 32'(valid), 0);
        idle_rest();

        // Capture disabled for two slots
        slot(1'b1, 1'b0, DST_REG, 3);
        check("en0_valid_a", 32'(valid), 0);
        check("en0_reg_sb", 32'(reg_sb), 0);
        slot(1'b1, 1'b0, DST_P, 0);
        check("en0_valid_b", 32'(valid), 0);
        check("en0_pred_sb", 32'(pred_sb), 0);
        slot(1'b1, 1'b1, DST_REG, 7);
        check("en1_rec", 32'(rec), mk(3, DST_REG, 7));
        check("en1_reg_sb", 32'(reg_sb), 32'h0080);
        tick(0, 1'b0, 1'b1, DST_NONE, 0);
        idle_rest();

        // Reset at ctr==2 of a running slot abandons it
        tick(0, 1'b1, 1'b1, DST_REG, 9);
        tick(1, 1'b1, 1'b1, DST_REG, 9);
        rst = 1'b1;
        tick(2, 1'b1, 1'b1, DST_REG, 9);
        rst = 1'b0;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_rec", 32'(rec), 0);
        check("mid_rst_reg_sb", 32'(reg_sb), 0);
        check("mid_rst_pred_sb", 32'(pred_sb), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_drop", 32'(drop_cnt), 0);
        tick(3, 1'b1, 1'b1, DST_REG, 9);
        check("mid_rst_no_rec", 32'(valid), 0);
        slot(1'b1, 1'b1, DST_REG, 2);
        check("post_rst_seq0", 32'(rec), mk(0, DST_REG, 2));
        tick(0, 1'b0, 1'b1, DST_NONE, 0);
        idle_rest();

        // Fresh reset, then overflow: 10 retires into 8 entries
        rst = 1'b1;
        tick(0, 1'b0, 1'b0, DST_NONE, 0);
        rst   = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 10; i++) slot(1'b1, 1'b1, DST_REG, i);
        check("ovf_valid", 32'(valid), 1);
        check("ovf_flag", 32'(ovf), 1);
        check("ovf_drop_cnt", 32'(drop_cnt), 2);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_valid", 32'(valid), 1);
            check("ovf_drain_seq", 32'(rec.seq), 32'(i));
            tick(i % 4, 1'b0, 1'b1, DST_NONE, 0);
        end
        check("ovf_drained", 32'(valid), 0);
        slot(1'b1, 1'b1, DST_P, 0);
        check("ovf_next_seq", 32'(rec), mk(10, DST_P, 0));
        tick(0, 1'b0, 1'b1, DST_NONE, 0);
        ovf_clr = 1'b1;
        tick(1, 1'b0, 1'b1, DST_NONE, 0);
        ovf_clr = 1'b0;
        check("ovf_clr_flag", 32'(ovf), 0);
        check("ovf_clr_cnt", 32'(drop_cnt), 0);
        tick(2, 1'b0, 1'b1, DST_NONE, 0);
        tick(3, 1'b0, 1'b1, DST_NONE, 0);

        // Full FIFO with a pop on the retire edge: no drop
        ready = 1'b0;
        for (int i = 0; i < 8; i++) slot(1'b1, 1'b1, DST_REG, 1);
        check("full_no_ovf", 32'(ovf), 0);
        check("full_head", 32'(rec.seq), 11);
        for (int c = 0; c < 3; c++) tick(c, 1'b1, 1'b1, DST_REG, 1);
        ready = 1'b1;
        tick(3, 1'b1, 1'b1, DST_REG, 1);
        ready = 1'b0;
        check("pushpop_ovf", 32'(ovf), 0);
        check("pushpop_drop", 32'(drop_cnt), 0);
        check("pushpop_head", 32'(rec.seq), 12);

        // Still full: a drop coinciding with ovf_clr leaves ovf=1, count=1
        for (int c = 0; c < 3; c++) tick(c, 1'b1, 1'b1, DST_REG, 1);
        ovf_clr = 1'b1;
        tick(3, 1'b1, 1'b1, DST_REG, 1);
        ovf_clr = 1'b0;
        check("clr_drop_ovf", 32'(ovf), 1);
        check("clr_drop_cnt", 32'(drop_cnt), 1);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("full_drain_seq", 32'(rec.seq), 32'(12 + i));
            tick(i % 4, 1'b0, 1'b1, DST_NONE, 0);
        end
        check("full_drained", 32'(valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
